// File: rtl/deadlock_report_ctrl.sv
// Elects one origin from the detect units' cycle flags, confirms that it stays
// blocked for CONFIRM_CYCLES, then latches a sticky report or pulses token_clear.
module deadlock_report_ctrl #(
  parameter int PROC_NUM       = 2,
  parameter int CONFIRM_CYCLES = 16,
  parameter int IDX_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] ap_done_reg_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                deadlock_found,
  output logic [IDX_W-1:0]    report_idx,
  output logic [PROC_NUM-1:0] report_done_mask,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_CLEAR   = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_detect, w_detect_nxt;
  logic [PROC_NUM-1:0] r_origin, w_origin_nxt;
  logic                r_token_clear, w_token_clear_nxt;
  logic                r_found, w_found_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [PROC_NUM-1:0] r_mask, w_mask_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic [PROC_NUM-1:0] w_lowest;
  logic [IDX_W-1:0]    w_origin_idx;
  logic                w_sel;

  // Two's-complement trick isolates the lowest set bit: lowest index wins ties.
  assign w_lowest = dl_in_vec & (~dl_in_vec + PROC_NUM'(1));
  assign w_sel    = |(dl_in_vec & r_origin);

  always_comb begin
    w_origin_idx = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      if (r_origin[i]) w_origin_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      r_state       <= S_IDLE;
      r_detect      <= 1'b0;
      r_origin      <= '0;
      r_token_clear <= 1'b0;
      r_found       <= 1'b0;
      r_idx         <= '0;
      r_mask        <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_detect      <= w_detect_nxt;
      r_origin      <= w_origin_nxt;
      r_token_clear <= w_token_clear_nxt;
      r_found       <= w_found_nxt;
      r_idx         <= w_idx_nxt;
      r_mask        <= w_mask_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_detect_nxt      = r_detect;
    w_origin_nxt      = r_origin;
    w_token_clear_nxt = 1'b0;
    w_found_nxt       = r_found;
    w_idx_nxt         = r_idx;
    w_mask_nxt        = r_mask;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|dl_in_vec) begin
          w_origin_nxt = w_lowest;
          w_detect_nxt = 1'b1;
          w_cnt_nxt    = CNT_W'(1);
          w_state_nxt  = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        // Only the elected origin's bit matters until the confirm resolves.
        if (w_sel) begin
          if (r_cnt == CNT_MAX) begin
            w_state_nxt = S_REPORT;
            w_found_nxt = 1'b1;
            w_idx_nxt   = w_origin_idx;
            w_mask_nxt  = ap_done_reg_vec;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt       = S_CLEAR;
          w_token_clear_nxt = 1'b1;
          w_detect_nxt      = 1'b0;
          w_origin_nxt      = '0;
          w_cnt_nxt         = '0;
        end
      end
      S_CLEAR:  w_state_nxt = S_IDLE;
      S_REPORT: w_state_nxt = S_REPORT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign dl_detect_out    = r_detect;
  assign origin           = r_origin;
  assign token_clear      = r_token_clear;
  assign deadlock_found   = r_found;
  assign report_idx       = r_idx;
  assign report_done_mask = r_mask;
  assign dbg_state        = r_state;

endmodule
